// File: rtl/board_controller.sv
// Tic-tac-toe game-state owner: holds X/O occupancy, arbitrates AI and human
// moves, enforces legality and turn order, and reports win/draw status.
module board_controller #(
  parameter int AI_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] player_move,
  input  logic       player_valid,
  input  logic [8:0] ai_move,
  output logic [8:0] x_state,
  output logic [8:0] o_state,
  output logic       human_turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       move_err,
  output logic       ai_fallback,
  output logic [2:0] dbg_state
);

  localparam int CW = (AI_DELAY > 1) ? $clog2(AI_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(AI_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AI_WAIT = 3'd1,
    S_CHECK_X = 3'd2,
    S_HUMAN   = 3'd3,
    S_CHECK_O = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    x_n, o_n, occ;
  logic [1:0]    winner_n;
  logic          move_err_n, ai_fallback_n;

  // Legal = exactly one bit set, landing on an empty cell.
  function automatic logic is_legal(input logic [8:0] mv, input logic [8:0] used);
    return (mv != 9'd0) && ((mv & (mv - 9'd1)) == 9'd0) && ((mv & used) == 9'd0);
  endfunction

  // Scanning downward leaves the lowest-index empty cell as the final pick.
  function automatic logic [8:0] first_empty(input logic [8:0] used);
    logic [8:0] r;
    r = 9'd0;
    for (int i = 8; i >= 0; i--) begin
      if (!used[i]) r = 9'd1 << i;
    end
    return r;
  endfunction

  function automatic logic has_line(input logic [8:0] b);
    return (b[8] & b[7] & b[6]) | (b[5] & b[4] & b[3]) | (b[2] & b[1] & b[0]) |
           (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
           (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
  endfunction

  assign occ = x_state | o_state;

  always_comb begin
    state_n       = state;
    x_n           = x_state;
    o_n           = o_state;
    winner_n      = winner;
    cnt_n         = cnt;
    move_err_n    = 1'b0;
    ai_fallback_n = 1'b0;
    // start wins over every state and over a same-cycle player_valid.
    if (start) begin
      x_n      = 9'd0;
      o_n      = 9'd0;
      winner_n = 2'b00;
      cnt_n    = CNT_LOAD;
      state_n  = S_AI_WAIT;
    end else begin
      case (state)
        S_AI_WAIT: begin
          if (cnt == '0) begin
            if (is_legal(ai_move, occ)) begin
              x_n = x_state | ai_move;
            end else begin
              x_n           = x_state | first_empty(occ);
              ai_fallback_n = 1'b1;
            end
            state_n = S_CHECK_X;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_CHECK_X: begin
          if (has_line(x_state)) begin
            winner_n = 2'b01;
            state_n  = S_DONE;
          end else if (occ == 9'h1ff) begin
            winner_n = 2'b11;
            state_n  = S_DONE;
          end else begin
            state_n = S_HUMAN;
          end
        end
        S_HUMAN: begin
          if (player_valid) begin
            if (is_legal(player_move, occ)) begin
              o_n     = o_state | player_move;
              state_n = S_CHECK_O;
            end else begin
              move_err_n = 1'b1;
            end
          end
        end
        S_CHECK_O: begin
          if (has_line(o_state)) begin
            winner_n = 2'b10;
            state_n  = S_DONE;
          end else if (occ == 9'h1ff) begin
            winner_n = 2'b11;
            state_n  = S_DONE;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = S_AI_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      x_state     <= 9'd0;
      o_state     <= 9'd0;
      winner      <= 2'b00;
      move_err    <= 1'b0;
      ai_fallback <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      x_state     <= x_n;
      o_state     <= o_n;
      winner      <= winner_n;
      move_err    <= move_err_n;
      ai_fallback <= ai_fallback_n;
    end
  end

  assign human_turn = (state == S_HUMAN);
  assign game_over  = (state == S_DONE);
  assign dbg_state  = state;

endmodule

// File: doc/board_controller.md
# board_controller

Sequential game-state owner for tic-tac-toe: holds the X (AI) and O (human) occupancy vectors, issues them to the combinational lookup AI, accepts the AI's one-hot move back, and accepts the human player's one-hot move. It enforces turn order and move legality, detects win/draw, and reports game status to the display/LED logic. The AI always plays X and moves first.

## Interface
- `AI_DELAY`, default 4: cycles the AI move is allowed to settle before being sampled; legal range ≥1.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse; clears the board and begins a new game, including mid-game.
- `player_move` input 9: human move, one-hot; bit 8 = top-left, row-major, bit 0 = bottom-right.
- `player_valid` input 1: qualifies `player_move` for one cycle.
- `ai_move` input 9: one-hot move from the lookup AI; all-zero means no entry.
- `x_state` output 9: X occupancy, registered; drives AI input and display.
- `o_state` output 9: O occupancy, registered; drives AI input and display.
- `human_turn` output 1: high while the block is waiting for the human move.
- `game_over` output 1: high in DONE.
- `winner` output 2: 00 none, 01 X, 10 O, 11 draw.
- `move_err` output 1: one-cycle pulse on a rejected human move.
- `ai_fallback` output 1: one-cycle pulse when the AI move was replaced.

Reset and synchronicity are fixed: one clock, and `rst` is synchronous and active-high.

## Operation
- **States:** IDLE, AI_WAIT, CHECK_X, HUMAN, CHECK_O, DONE.
- **Reset:**
  - State goes to IDLE; all outputs and the counter clear to 0.
  - `rst` has priority over everything, including `start`.
- **`start`:**
  - Sampled in any state.
  - Clears `x_state`, `o_state` and `winner`, loads the counter with AI_DELAY-1, and moves to AI_WAIT.
  - Beats `player_valid` in the same cycle.
- **AI_WAIT:**
  - The counter decrements each cycle.
  - When the counter is 0, `ai_move` is sampled. If it is legal, it is ORed into `x_state`. Legal means exactly one bit set and that cell empty in `x_state | o_state`.
  - If it is not legal (zero, multi-hot, or occupied), the lowest-index empty cell is taken instead (bit 0 first), and `ai_fallback` pulses.
  - Then go to CHECK_X.
- **CHECK_X:**
  - Evaluates the registered `x_state` against the 8 lines: rows {8,7,6}, {5,4,3}, {2,1,0}; columns {8,5,2}, {7,4,1}, {6,3,0}; diagonals {8,4,0}, {6,4,2}.
  - Win: `winner`=01, go to DONE.
  - Otherwise, if the board is full: `winner`=11, go to DONE.
  - Otherwise go to HUMAN.
- **HUMAN:**
  - `human_turn`=1. Waits indefinitely for `player_valid`.
  - Legal `player_move` (same rule as for the AI): ORed into `o_state`, go to CHECK_O.
  - Illegal `player_move`: board unchanged, `move_err` pulses, stay in HUMAN.
- **CHECK_O:**
  - O win: `winner`=10, go to DONE.
  - Otherwise, if full: `winner`=11, go to DONE.
  - Otherwise load the counter with AI_DELAY-1 and go to AI_WAIT.
- **DONE:**
  - The board and `winner` hold.
  - Only `start` or `rst` leaves this state.
- **Ignored inputs:**
  - `player_valid` outside HUMAN is ignored; no `move_err`.
  - `ai_move` outside the sampling cycle is ignored.
- Exactly one bit is added per move. `x_state & o_state` is always 0.

## Timing
- All outputs are registered. `move_err` and `ai_fallback` are high for exactly the one cycle after the sampling edge.
- With `start` sampled at edge E0:
  - `x_state` updates at edge E(AI_DELAY).
  - CHECK_X occupies the next cycle.
  - `human_turn` rises after edge E(AI_DELAY+1).
- With a legal `player_valid` sampled at edge H:
  - `o_state` updates at edge H and `human_turn` falls at edge H.
  - CHECK_O occupies the cycle after edge H.
  - AI_WAIT is entered at edge H+1.
  - The next `x_state` update is at edge H+1+AI_DELAY.
- AI_DELAY=1: the AI move is sampled on the first AI_WAIT cycle.
- `game_over` and `winner` become valid at the edge that leaves CHECK_X or CHECK_O.
- A `start` during AI_WAIT aborts the pending AI move; the counter is reloaded.

## Test plan
- **Reset value check:** hold `rst` 2 cycles, release → all outputs 0, `human_turn`=0, `game_over`=0.
- **First AI move, AI_DELAY=4:** `start` pulse, `ai_move`=0x100 → `x_state`=0x100 after 4 edges, `human_turn`=1 one edge later.
- **Illegal human moves:** in HUMAN, drive `player_move`=0x100 (occupied), then 0x003 (multi-hot) → `move_err` pulses twice, board unchanged. Then drive 0x001 → `o_state`=0x001, `human_turn`=0.
- **AI fallback:** `ai_move`=0x000 with board x=0x100, o=0x001 → `x_state`=0x102, `ai_fallback` pulse.
- **X win:** script the moves
  - X 0x100, O 0x001, X 0x040, O 0x002, X 0x080.
  - Expect `winner`=01, `game_over`=1.
  - A subsequent `player_valid` is ignored.
- **Draw and restart:**
  - Play to a full board with no line → `winner`=11.
  - `start` mid-game (in HUMAN) → board clears, AI_WAIT entered, `winner`=00.
  - `start` and `rst` together → IDLE.
